fetch_pc_ctrl: RTL and testbench

// - Fetch-stage controller: owns the PC, issues instruction-memory reads, absorbs multi-cycle memory stalls,

---
 rtl/fetch_pc_ctrl_pkg.sv | 19 +
 rtl/core_cells.sv | 45 ++++
 rtl/fetch_pc_ctrl_hold_buf.sv | 48 ++++
 rtl/fetch_pc_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_pc_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_pc_ctrl_pkg : shared fetch-stage constants and state codes |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package fetch_pc_ctrl_pkg;

    localparam int unsigned C_WIDTH     = 16;
    localparam logic [15:0] C_RESET_PC  = 16'h0000;
    localparam logic [15:0] C_NOP_INSTR = 16'h0800;

    typedef enum logic [1:0] {
        S_RUN  = 2'b00,
        S_WAIT = 2'b01,
        S_HALT = 2'b10
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/core_cells.sv
`default_nettype none
// +------------------------------------------------------------------+
// | core_dff / core_add : enabled flop cell and adder                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module core_dff #(
    parameter int unsigned       WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic r_bit;
        logic w_next;
        assign w_next = en ? d[i] : r_bit;
        // Reset is active-low and synchronous
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_bit <= RST_VAL[i];
            end else begin
                r_bit <= w_next;
            end
        end
        assign q[i] = r_bit;
    end

endmodule

module core_add #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule
`default_nettype wire

// File: rtl/fetch_pc_ctrl_hold_buf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_hold_buf : one-entry instr / pc+2 buffer for stalled reads |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fetch_hold_buf #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic             i_drain,
    input  logic [WIDTH-1:0] i_instr,
    input  logic [WIDTH-1:0] i_pc2,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_instr,
    output logic [WIDTH-1:0] o_pc2
);

    logic w_valid_d;

    // Clear (redirect/halt) beats load, load beats drain
    always_comb begin
        w_valid_d = o_valid;
        if (i_clear) begin
            w_valid_d = 1'b0;
        end else if (i_load) begin
            w_valid_d = 1'b1;
        end else if (i_drain) begin
            w_valid_d = 1'b0;
        end
    end

    core_dff #(.WIDTH(1), .RST_VAL(1'b0)) u_valid (
        .clk(clk), .rst(rst), .en(1'b1), .d(w_valid_d), .q(o_valid)
    );

    core_dff #(.WIDTH(WIDTH), .RST_VAL('0)) u_instr (
        .clk(clk), .rst(rst), .en(i_load), .d(i_instr), .q(o_instr)
    );

    core_dff #(.WIDTH(WIDTH), .RST_VAL('0)) u_pc2 (
        .clk(clk), .rst(rst), .en(i_load), .d(i_pc2), .q(o_pc2)
    );

endmodule
`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_pc_ctrl : PC owner, imem request/stall handling, IF/ID out |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter int unsigned      WIDTH     = C_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC  = C_RESET_PC,
    parameter logic [WIDTH-1:0] NOP_INSTR = C_NOP_INSTR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             halt_i,
    input  logic             mem_done,
    input  logic             mem_stall,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0] pc_plus2_o,
    output logic             instr_valid,
    output logic             halted_o,
    output logic             err_o
);

    localparam logic [WIDTH-1:0] C_TWO = WIDTH'(2);

    logic [1:0]       r_state;
    fetch_state_e     w_state;
    fetch_state_e     w_state_d;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_d;
    logic             w_pc_en;
    logic [WIDTH-1:0] w_pc_plus2;
    logic [WIDTH-1:0] w_instr_d;
    logic             w_valid_d;
    logic             w_ifid_en;
    logic [WIDTH-1:0] w_pc2_d;
    logic             w_pc2_en;
    logic             w_err_d;
    logic             r_pend_valid;
    logic             w_pend_valid_d;
    logic [WIDTH-1:0] r_pend_pc;
    logic             w_pend_pc_en;
    logic             r_halt_pend;
    logic             w_halt_pend_d;
    logic             w_buf_load;
    logic             w_buf_clear;
    logic             w_buf_drain;
    logic             w_buf_valid;
    logic [WIDTH-1:0] w_buf_instr;
    logic [WIDTH-1:0] w_buf_pc2;
    logic             w_req;
    logic             w_done;
    logic             w_busy;

    assign w_state = fetch_state_e'(r_state);

    // PC doubles as the held address while a read is outstanding
    assign w_req    = (w_state == S_RUN)  ? (!stall_i && !w_buf_valid)
                                          : (w_state == S_WAIT);
    assign w_done   = w_req & mem_done;
    assign w_busy   = w_req & mem_stall;
    assign mem_req  = rst & w_req;
    assign mem_addr = r_pc;
    assign halted_o = (w_state == S_HALT);

    core_add #(.WIDTH(WIDTH)) u_pc_add (.a(r_pc), .b(C_TWO), .sum(w_pc_plus2));

    always_comb begin
        w_state_d      = w_state;
        w_pc_en        = 1'b0;
        w_pc_d         = w_pc_plus2;
        w_ifid_en      = 1'b0;
        w_instr_d      = NOP_INSTR;
        w_valid_d      = 1'b0;
        w_pc2_en       = 1'b0;
        w_pc2_d        = w_pc_plus2;
        w_err_d        = 1'b0;
        w_pend_valid_d = r_pend_valid;
        w_pend_pc_en   = 1'b0;
        w_halt_pend_d  = r_halt_pend;
        w_buf_load     = 1'b0;
        w_buf_clear    = 1'b0;
        w_buf_drain    = 1'b0;
        case (w_state)
            S_RUN: begin
                if (redirect_i) begin
                    w_ifid_en   = 1'b1;
                    w_buf_clear = 1'b1;
                    if (redirect_pc[0]) begin
                        w_err_d   = 1'b1;
                        w_state_d = S_HALT;
                    end else if (w_busy) begin
                        // Memory accepted the read; target waits until it returns
                        w_state_d      = S_WAIT;
                        w_pend_valid_d = 1'b1;
                        w_pend_pc_en   = 1'b1;
                    end else begin
                        w_pc_en = 1'b1;
                        w_pc_d  = redirect_pc;
                    end
                end else if (halt_i) begin
                    w_ifid_en   = 1'b1;
                    w_buf_clear = 1'b1;
                    if (w_busy) begin
                        w_state_d     = S_WAIT;
                        w_halt_pend_d = 1'b1;
                    end else begin
                        w_state_d = S_HALT;
                    end
                end else if (!stall_i) begin
                    w_ifid_en = 1'b1;
                    if (w_buf_valid) begin
                        w_instr_d   = w_buf_instr;
                        w_valid_d   = 1'b1;
                        w_pc2_en    = 1'b1;
                        w_pc2_d     = w_buf_pc2;
                        w_buf_drain = 1'b1;
                    end else if (w_done) begin
                        w_instr_d = mem_rdata;
                        w_valid_d = 1'b1;
                        w_pc2_en  = 1'b1;
                        w_pc_en   = 1'b1;
                    end else if (w_busy) begin
                        w_state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (redirect_i) begin
                    w_ifid_en     = 1'b1;
                    w_buf_clear   = 1'b1;
                    w_halt_pend_d = 1'b0;
                    if (redirect_pc[0]) begin
                        w_err_d        = 1'b1;
                        w_state_d      = S_HALT;
                        w_pend_valid_d = 1'b0;
                    end else if (mem_done) begin
                        w_pc_en        = 1'b1;
                        w_pc_d         = redirect_pc;
                        w_pend_valid_d = 1'b0;
                        w_state_d      = S_RUN;
                    end else begin
                        w_pend_valid_d = 1'b1;
                        w_pend_pc_en   = 1'b1;
                    end
                end else if (mem_done) begin
                    w_pc_en        = 1'b1;
                    w_pc_d         = r_pend_valid ? r_pend_pc : w_pc_plus2;
                    w_pend_valid_d = 1'b0;
                    w_halt_pend_d  = 1'b0;
                    if (halt_i || r_halt_pend) begin
                        w_state_d = S_HALT;
                        w_ifid_en = 1'b1;
                    end else begin
                        w_state_d = S_RUN;
                        if (r_pend_valid) begin
                            w_ifid_en = 1'b1;
                        end else if (stall_i) begin
                            w_buf_load = 1'b1;
                        end else begin
                            w_ifid_en = 1'b1;
                            w_instr_d = mem_rdata;
                            w_valid_d = 1'b1;
                            w_pc2_en  = 1'b1;
                        end
                    end
                end else if (halt_i) begin
                    w_halt_pend_d = 1'b1;
                    w_ifid_en     = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    core_dff #(.WIDTH(2), .RST_VAL(S_RUN)) u_state (
        .clk(clk), .rst(rst), .en(1'b1), .d(w_state_d), .q(r_state)
    );

    core_dff #(.WIDTH(WIDTH), .RST_VAL(RESET_PC)) u_pc (
        .clk(clk), .rst(rst), .en(w_pc_en), .d(w_pc_d), .q(r_pc)
    );

    core_dff #(.WIDTH(WIDTH), .RST_VAL(NOP_INSTR)) u_instr (
        .clk(clk), .rst(rst), .en(w_ifid_en), .d(w_instr_d), .q(instr_o)
    );

    core_dff #(.WIDTH(1), .RST_VAL(1'b0)) u_valid (
        .clk(clk), .rst(rst), .en(w_ifid_en), .d(w_valid_d), .q(instr_valid)
    );

    core_dff #(.WIDTH(WIDTH), .RST_VAL('0)) u_pc2 (
        .clk(clk), .rst(rst), .en(w_pc2_en), .d(w_pc2_d), .q(pc_plus2_o)
    );

    core_dff #(.WIDTH(1), .RST_VAL(1'b0)) u_err (
        .clk(clk), .rst(rst), .en(1'b1), .d(w_err_d), .q(err_o)
    );

    core_dff #(.WIDTH(1), .RST_VAL(1'b0)) u_pend_valid (
        .clk(clk), .rst(rst), .en(1'b1), .d(w_pend_valid_d), .q(r_pend_valid)
    );

    core_dff #(.WIDTH(WIDTH), .RST_VAL('0)) u_pend_pc (
        .clk(clk), .rst(rst), .en(w_pend_pc_en), .d(redirect_pc), .q(r_pend_pc)
    );

    core_dff #(.WIDTH(1), .RST_VAL(1'b0)) u_halt_pend (
        .clk(clk), .rst(rst), .en(1'b1), .d(w_halt_pend_d), .q(r_halt_pend)
    );

    fetch_hold_buf #(.WIDTH(WIDTH)) u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_buf_load),
        .i_clear (w_buf_clear),
        .i_drain (w_buf_drain),
        .i_instr (mem_rdata),
        .i_pc2   (w_pc_plus2),
        .o_valid (w_buf_valid),
        .o_instr (w_buf_instr),
        .o_pc2   (w_buf_pc2)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fetch_pc_ctrl : directed bench for fetch_pc_ctrl              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, redirect_i, halt_i, mem_done, mem_stall;
    logic [15:0] redirect_pc, mem_rdata;
    logic        mem_req, instr_valid, halted_o, err_o;
    logic [15:0] mem_addr, instr_o, pc_plus2_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_pc_ctrl u_dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc(redirect_pc), .halt_i(halt_i), .mem_done(mem_done),
        .mem_stall(mem_stall), .mem_rdata(mem_rdata), .mem_req(mem_req),
        .mem_addr(mem_addr), .instr_o(instr_o), .pc_plus2_o(pc_plus2_o),
        .instr_valid(instr_valid), .halted_o(halted_o), .err_o(err_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_i = 0; redirect_i = 0; halt_i = 0; mem_done = 0; mem_stall = 0;
        redirect_pc = 16'h0000; mem_rdata = 16'h0000;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        tick();
        tick();
        rst = 1;
    endtask

    task automatic test_reset();
        idle();
        rst = 0; mem_done = 1; mem_rdata = 16'hFFFF;
        tick(); tick();
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_tests++; if (instr_o !== 16'h0800) begin n_fail++; $display("FAIL reset_instr: got %h want 0800", instr_o); end
        n_tests++; if (pc_plus2_o !== 16'h0000) begin n_fail++; $display("FAIL reset_pc2: got %h want 0000", pc_plus2_o); end
        n_tests++; if (halted_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL reset_halt_err: got %b%b want 00", halted_o, err_o); end
        rst = 1; mem_done = 0;
        #1;
        n_tests++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
        n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL reset_release_req: got %b want 1", mem_req); end
    endtask

    task automatic test_streaming();
        mem_done = 1; mem_rdata = 16'hA001;
        tick();
        n_tests++; if (instr_o !== 16'hA001 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL stream_instr0: got %h/%b want A001/1", instr_o, instr_valid); end
        n_tests++; if (pc_plus2_o !== 16'h0002) begin n_fail++; $display("FAIL stream_pc2_0: got %h want 0002", pc_plus2_o); end
        n_tests++; if (mem_addr !== 16'h0002) begin n_fail++; $display("FAIL stream_addr1: got %h want 0002", mem_addr); end
        mem_rdata = 16'hA002;
        tick();
        n_tests++; if (instr_o !== 16'hA002 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL stream_instr1: got %h/%b want A002/1", instr_o, instr_valid); end
        n_tests++; if (pc_plus2_o !== 16'h0004) begin n_fail++; $display("FAIL stream_pc2_1: got %h want 0004", pc_plus2_o); end
        mem_done = 0;
    endtask

    task automatic test_mem_stall();
        mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (mem_addr !== 16'h0004 || mem_req !== 1'b1) begin n_fail++; $display("FAIL mstall_addr%0d: got %h/%b want 0004/1", i, mem_addr, mem_req); end
            n_tests++; if (instr_valid !== 1'b0 || instr_o !== 16'h0800) begin n_fail++; $display("FAIL mstall_valid%0d: got %b/%h want 0/0800", i, instr_valid, instr_o); end
        end
        mem_stall = 0; mem_done = 1; mem_rdata = 16'hB004;
        tick();
        n_tests++; if (instr_o !== 16'hB004 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL mstall_deliver: got %h/%b want B004/1", instr_o, instr_valid); end
        n_tests++; if (pc_plus2_o !== 16'h0006 || mem_addr !== 16'h0006) begin n_fail++; $display("FAIL mstall_pc: got %h/%h want 0006/0006", pc_plus2_o, mem_addr); end
        mem_done = 0;
    endtask

    task automatic test_redirect_wait();
        mem_done = 1; mem_rdata = 16'hC006;
        tick();
        mem_done = 0; mem_stall = 1;
        tick();
        n_tests++; if (mem_addr !== 16'h0008) begin n_fail++; $display("FAIL rwait_stall_addr: got %h want 0008", mem_addr); end
        redirect_i = 1; redirect_pc = 16'h0040;
        tick();
        n_tests++; if (instr_valid !== 1'b0 || mem_addr !== 16'h0008) begin n_fail++; $display("FAIL rwait_held: got %b/%h want 0/0008", instr_valid, mem_addr); end
        redirect_i = 0; mem_stall = 0; mem_done = 1; mem_rdata = 16'hDEAD;
        tick();
        n_tests++; if (instr_valid !== 1'b0 || instr_o !== 16'h0800) begin n_fail++; $display("FAIL rwait_drop: got %b/%h want 0/0800", instr_valid, instr_o); end
        n_tests++; if (mem_addr !== 16'h0040 || mem_req !== 1'b1) begin n_fail++; $display("FAIL rwait_target: got %h/%b want 0040/1", mem_addr, mem_req); end
        mem_rdata = 16'hE040;
        tick();
        n_tests++; if (instr_o !== 16'hE040 || pc_plus2_o !== 16'h0042) begin n_fail++; $display("FAIL rwait_next: got %h/%h want E040/0042", instr_o, pc_plus2_o); end
        mem_done = 0;
    endtask

    task automatic test_misaligned();
        redirect_i = 1; redirect_pc = 16'h0041;
        tick();
        n_tests++; if (err_o !== 1'b1 || halted_o !== 1'b1) begin n_fail++; $display("FAIL mis_err: got %b/%b want 1/1", err_o, halted_o); end
        n_tests++; if (mem_req !== 1'b0 || mem_addr !== 16'h0042) begin n_fail++; $display("FAIL mis_req: got %b/%h want 0/0042", mem_req, mem_addr); end
        redirect_i = 0;
        tick();
        n_tests++; if (err_o !== 1'b0 || halted_o !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got %b/%b want 0/1", err_o, halted_o); end
        redirect_i = 1; redirect_pc = 16'h0080; halt_i = 1; mem_done = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (mem_req !== 1'b0 || halted_o !== 1'b1 || mem_addr !== 16'h0042 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL mis_hold%0d: got req %b halt %b addr %h v %b", i, mem_req, halted_o, mem_addr, instr_valid); end
        end
        idle();
        rst = 0;
        tick();
        n_tests++; if (halted_o !== 1'b0) begin n_fail++; $display("FAIL mis_reset_exit: got %b want 0", halted_o); end
        rst = 1;
    endtask

    task automatic test_halt_wrap();
        do_reset();
        redirect_i = 1; redirect_pc = 16'hFFFE;
        tick();
        n_tests++; if (mem_addr !== 16'hFFFE) begin n_fail++; $display("FAIL hwrap_target: got %h want FFFE", mem_addr); end
        redirect_i = 0; halt_i = 1; stall_i = 1;
        tick();
        n_tests++; if (halted_o !== 1'b1 || mem_req !== 1'b0 || mem_addr !== 16'hFFFE) begin n_fail++; $display("FAIL hwrap_nofetch: got %b/%b/%h want 1/0/FFFE", halted_o, mem_req, mem_addr); end
        do_reset();
        redirect_i = 1; redirect_pc = 16'hFFFE;
        tick();
        redirect_i = 0; mem_stall = 1;
        tick();
        halt_i = 1;
        tick();
        n_tests++; if (halted_o !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'hFFFE) begin n_fail++; $display("FAIL hwrap_drain: got %b/%b/%h want 0/1/FFFE", halted_o, mem_req, mem_addr); end
        halt_i = 0; mem_stall = 0; mem_done = 1; mem_rdata = 16'h1234;
        tick();
        n_tests++; if (halted_o !== 1'b1 || mem_addr !== 16'h0000 || mem_req !== 1'b0) begin n_fail++; $display("FAIL hwrap_wrapped: got %b/%h/%b want 1/0000/0", halted_o, mem_addr, mem_req); end
        n_tests++; if (instr_valid !== 1'b0 || instr_o !== 16'h0800) begin n_fail++; $display("FAIL hwrap_squash: got %b/%h want 0/0800", instr_valid, instr_o); end
        idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem_stall = 1;
        tick();
        mem_stall = 0; stall_i = 1; mem_done = 1; mem_rdata = 16'h5150;
        tick();
        n_tests++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_buffered: got %b/%b want 0/0", instr_valid, mem_req); end
        mem_done = 0;
        tick();
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_held: got %b want 0", instr_valid); end
        stall_i = 0;
        #1;
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_drain_req: got %b want 0", mem_req); end
        tick();
        n_tests++; if (instr_o !== 16'h5150 || instr_valid !== 1'b1 || pc_plus2_o !== 16'h0002) begin n_fail++; $display("FAIL b2b_present: got %h/%b/%h want 5150/1/0002", instr_o, instr_valid, pc_plus2_o); end
        n_tests++; if (mem_addr !== 16'h0002 || mem_req !== 1'b1) begin n_fail++; $display("FAIL b2b_resume: got %h/%b want 0002/1", mem_addr, mem_req); end
        mem_done = 1; mem_rdata = 16'h6002;
        tick();
        n_tests++; if (instr_o !== 16'h6002 || pc_plus2_o !== 16'h0004) begin n_fail++; $display("FAIL b2b_stream: got %h/%h want 6002/0004", instr_o, pc_plus2_o); end
        stall_i = 1; mem_rdata = 16'h7777;
        tick();
        n_tests++; if (instr_o !== 16'h6002 || instr_valid !== 1'b1 || mem_addr !== 16'h0004) begin n_fail++; $display("FAIL b2b_dstall: got %h/%b/%h want 6002/1/0004", instr_o, instr_valid, mem_addr); end
        stall_i = 0; mem_done = 0; redirect_i = 1; redirect_pc = 16'h0100; halt_i = 1;
        tick();
        n_tests++; if (halted_o !== 1'b0 || mem_addr !== 16'h0100 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_redir_halt: got %b/%h/%b want 0/0100/0", halted_o, mem_addr, instr_valid); end
        idle();
    endtask

    initial begin
        idle();
        rst = 0;
        test_reset();
        test_streaming();
        test_mem_stall();
        test_redirect_wait();
        test_misaligned();
        test_halt_wrap();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
